// File: rtl/bram_port_arbiter.sv
// Arbiter sharing one cache-line BRAM between the inst and data crypto units.
// One transaction in flight; data has priority with bounded inst starvation.
module bram_port_arbiter #(
  parameter int MEM_ADDR_BITS   = 15,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     i_req,
  input  logic                     i_write,
  input  logic [MEM_ADDR_BITS-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  output logic                     i_valid,
  input  logic                     d_req,
  input  logic                     d_write,
  input  logic [MEM_ADDR_BITS-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_valid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     timeout_err,
  output logic                     mem_req,
  output logic                     mem_write,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_valid
);

  localparam int SW = (MAX_DATA_STREAK < 2) ? 1
                    : $clog2(MAX_DATA_STREAK + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                   state, state_n;
  logic                     owner_d, owner_d_n;
  logic [SW-1:0]            streak, streak_n;
  logic [TW-1:0]            timer, timer_n;
  logic                     grant_d;
  logic                     i_valid_n, d_valid_n, terr_n;
  logic                     mem_req_n, mem_write_n;
  logic [MEM_ADDR_BITS-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0]    mem_wdata_n, rdata_n;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      streak      <= '0;
      timer       <= '0;
      i_valid     <= 1'b0;
      d_valid     <= 1'b0;
      timeout_err <= 1'b0;
      rdata       <= '0;
      mem_req     <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_n;
      owner_d     <= owner_d_n;
      streak      <= streak_n;
      timer       <= timer_n;
      i_valid     <= i_valid_n;
      d_valid     <= d_valid_n;
      timeout_err <= terr_n;
      rdata       <= rdata_n;
      mem_req     <= mem_req_n;
      mem_write   <= mem_write_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    owner_d_n   = owner_d;
    streak_n    = streak;
    timer_n     = timer;
    grant_d     = 1'b0;
    i_valid_n   = 1'b0;
    d_valid_n   = 1'b0;
    terr_n      = 1'b0;
    rdata_n     = rdata;
    mem_req_n   = mem_req;
    mem_write_n = mem_write;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_d     = d_req && (!i_req || streak != SMAX);
          owner_d_n   = grant_d;
          mem_req_n   = 1'b1;
          mem_write_n = grant_d ? d_write : i_write;
          mem_addr_n  = grant_d ? d_addr  : i_addr;
          mem_wdata_n = grant_d ? d_wdata : i_wdata;
          timer_n     = '0;
          state_n     = ISSUE;
          // inst still waiting only when data won over it, never past SMAX
          if (grant_d && i_req) streak_n = streak + SW'(1);
          else                  streak_n = '0;
        end
      end
      ISSUE: begin
        if (mem_valid) begin
          rdata_n   = mem_rdata;
          mem_req_n = 1'b0;
          i_valid_n = !owner_d;
          d_valid_n = owner_d;
          state_n   = RESP;
        end else if (TO_EN && timer == TLAST) begin
          rdata_n   = '0;
          mem_req_n = 1'b0;
          terr_n    = 1'b1;
          i_valid_n = !owner_d;
          d_valid_n = owner_d;
          state_n   = RESP;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural BRAM model.
// Completions are checked in order against expectations queued at stimulus.
module tb_bram_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 128;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          i_req = 1'b0, i_write = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic          i_valid;
  logic          d_req = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_valid;
  logic [DW-1:0] rdata;
  logic          timeout_err;
  logic          mem_req, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;

  always #5 HCLK = ~HCLK;

  bram_port_arbiter #(
    .MEM_ADDR_BITS(AW),
    .DATA_WIDTH(DW),
    .MAX_DATA_STREAK(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .i_req(i_req), .i_write(i_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_valid(i_valid),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_valid(d_valid),
    .rdata(rdata), .timeout_err(timeout_err),
    .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    bit            chk_data;
    bit            terr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic void expect_txn(input bit port,
                                     input logic [DW-1:0] d,
                                     input bit chk,
                                     input bit terr);
    exp_t e;
    e.port     = port;
    e.data     = d;
    e.chk_data = chk;
    e.terr     = terr;
    sbq.push_back(e);
  endfunction

  function automatic logic [DW-1:0] line_init(input logic [AW-1:0] a);
    return {4{16'hC0DE, 1'b0, a}};
  endfunction

  // BRAM model: answers after lat cycles of mem_req, or never when hung
  logic [DW-1:0] bram [int];
  bit hang = 1'b0;
  int lat  = 2;
  int mcnt = 0;

  function automatic logic [DW-1:0] rd_line(input logic [AW-1:0] a);
    if (bram.exists(int'(a))) return bram[int'(a)];
    return line_init(a);
  endfunction

  always @(negedge HCLK) begin
    mem_valid = 1'b0;
    if (mem_req && !hang) begin
      mcnt++;
      if (mcnt >= lat) begin
        mem_valid = 1'b1;
        mem_rdata = rd_line(mem_addr);
        if (mem_write) bram[int'(mem_addr)] = mem_wdata;
        mcnt = 0;
      end
    end else begin
      mcnt = 0;
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (i_valid && d_valid) begin
        check("dual_valid", 1, 0);
      end else if (i_valid || d_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_valid", {i_valid, d_valid}, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("port", d_valid, mon_e.port);
          if (mon_e.chk_data) check("rdata", rdata, mon_e.data);
          check("timeout_err", timeout_err, mon_e.terr);
        end
      end else if (timeout_err) begin
        check("stray_timeout_err", 1, 0);
      end
    end
  end

  task automatic txn(input bit port, input bit wr,
                     input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input bit keep);
    bit seen = 1'b0;
    if (port) begin
      d_req = 1'b1; d_write = wr; d_addr = a; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_write = wr; i_addr = a; i_wdata = wd;
    end
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge HCLK);
      seen = port ? d_valid : i_valid;
    end
    if (!seen) check(port ? "d_wait" : "i_wait", 0, 1);
    if (!keep) begin
      if (port) d_req = 1'b0;
      else      i_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  seen;
    repeat (3) @(negedge HCLK);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_i_valid", i_valid, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // single data read, exact latency
    expect_txn(1, line_init(15'h10), 1, 0);
    d_req = 1'b1; d_write = 1'b0; d_addr = 15'h10;
    @(negedge HCLK);
    check("t1_mreq_t1", mem_req, 1);
    check("t1_maddr", mem_addr, 15'h10);
    @(negedge HCLK);
    check("t1_mreq_t2", mem_req, 1);
    check("t1_dvalid_t2", d_valid, 0);
    @(negedge HCLK);
    check("t1_mreq_t3", mem_req, 0);
    check("t1_dvalid_t3", d_valid, 1);
    check("t1_ivalid_t3", i_valid, 0);
    d_req = 1'b0;
    repeat (2) @(negedge HCLK);

    // simultaneous requests: data first
    expect_txn(1, line_init(15'h11), 1, 0);
    expect_txn(0, line_init(15'h12), 1, 0);
    fork
      txn(1, 0, 15'h11, '0, 0);
      txn(0, 0, 15'h12, '0, 0);
    join
    repeat (2) @(negedge HCLK);

    // streak limit: 4 data grants, then inst, then data again
    for (int k = 0; k < 4; k++)
      expect_txn(1, line_init(15'h100 + 15'(k)), 1, 0);
    expect_txn(0, line_init(15'h200), 1, 0);
    expect_txn(1, line_init(15'h104), 1, 0);
    fork
      begin
        for (int k = 0; k < 5; k++)
          txn(1, 0, 15'h100 + 15'(k), '0, k < 4);
      end
      txn(0, 0, 15'h200, '0, 0);
    join
    repeat (2) @(negedge HCLK);

    // write then read back
    expect_txn(1, '0, 0, 0);
    txn(1, 1, 15'h20, {16{8'hA5}}, 0);
    expect_txn(1, {16{8'hA5}}, 1, 0);
    txn(1, 0, 15'h20, '0, 0);
    repeat (2) @(negedge HCLK);

    // reset during ISSUE aborts silently
    hang = 1'b1;
    d_req = 1'b1; d_write = 1'b0; d_addr = 15'h40;
    repeat (3) @(negedge HCLK);
    check("t6_in_issue", mem_req, 1);
    d_req = 1'b0;
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("t6_mem_req", mem_req, 0);
    check("t6_d_valid", d_valid, 0);
    check("t6_i_valid", i_valid, 0);
    check("t6_rdata", rdata, 0);
    check("t6_terr", timeout_err, 0);
    HRESETn = 1'b1;
    hang = 1'b0;
    @(negedge HCLK);
    check("t6_no_pulse", d_valid, 0);
    expect_txn(0, line_init(15'h50), 1, 0);
    txn(0, 0, 15'h50, '0, 0);
    repeat (2) @(negedge HCLK);

    // timeout: BRAM never answers
    hang = 1'b1;
    expect_txn(1, '0, 1, 1);
    d_req = 1'b1; d_write = 1'b0; d_addr = 15'h30;
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge HCLK);
      if (mem_req) cnt++;
      seen = d_valid;
    end
    check("t5_valid_seen", seen, 1);
    check("t5_mreq_cycles", cnt, 8);
    d_req = 1'b0;
    hang = 1'b0;
    @(negedge HCLK);
    expect_txn(1, line_init(15'h31), 1, 0);
    txn(1, 0, 15'h31, '0, 0);

    repeat (3) @(negedge HCLK);
    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
